// File: rtl/bcd_timer_ctrl.sv
// Multi-digit BCD stopwatch/timer run controller: IDLE/RUN/PAUSE/DONE sequencing,
// prescaled counting with a decade-digit carry chain, and an optional BCD stop target.
module bcd_timer_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  CLEAR,
    input  logic [4*DIGITS-1:0]   TARGET,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  TICK,
    output logic                  OVF,
    output logic                  RUNNING,
    output logic                  DONE
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [4*DIGITS-1:0]   bcd_reg, bcd_next;
    logic [4*DIGITS-1:0]   target_reg, target_next;
    logic [PW-1:0]         pre_reg, pre_next;
    logic                  tick_reg, tick_next;
    logic                  ovf_reg, ovf_next;
    logic                  running_reg, done_reg;

    logic [DIGITS:0]       carry;
    logic [4*DIGITS-1:0]   bcd_inc;
    logic [DIGITS-1:0]     digit_ok;
    logic                  tick_now;
    logic                  target_en;
    logic                  hit;
    logic [PW-1:0]         pre_adv;

    // Digit k advances only when every lower digit is 9; carry[DIGITS] flags all-9.
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit                 = bcd_reg[4*gi +: 4];
            assign carry[gi+1]           = carry[gi] && (digit == 4'd9);
            assign bcd_inc[4*gi +: 4]    = !carry[gi]       ? digit :
                                           (digit == 4'd9)  ? 4'd0  : digit + 4'd1;
            assign digit_ok[gi]          = (target_reg[4*gi +: 4] <= 4'd9);
        end
    endgenerate

    assign tick_now  = (state_reg == S_RUN) && (pre_reg == PRE_LAST);
    assign pre_adv   = (pre_reg == PRE_LAST) ? '0 : pre_reg + 1'b1;
    // A zero or non-BCD target disables the stop condition entirely.
    assign target_en = (|target_reg) && (&digit_ok);
    assign hit       = tick_now && target_en && (bcd_inc == target_reg);

    always_comb begin
        state_next  = state_reg;
        bcd_next    = bcd_reg;
        target_next = target_reg;
        pre_next    = pre_reg;
        tick_next   = 1'b0;
        ovf_next    = 1'b0;

        if (CLEAR) begin
            state_next = S_IDLE;
            bcd_next   = '0;
            pre_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (START) begin
                        state_next  = S_RUN;
                        target_next = TARGET;
                        pre_next    = '0;
                    end
                end
                S_RUN: begin
                    if (tick_now) begin
                        bcd_next  = bcd_inc;
                        tick_next = 1'b1;
                        ovf_next  = carry[DIGITS];
                    end
                    if (hit) begin
                        state_next = S_DONE;
                        pre_next   = pre_adv;
                    end else if (STOP) begin
                        // Pausing freezes the phase so resume keeps the same tick spacing.
                        state_next = S_PAUSE;
                        pre_next   = tick_now ? '0 : pre_reg;
                    end else begin
                        pre_next = pre_adv;
                    end
                end
                S_PAUSE: begin
                    if (START) begin
                        state_next = S_RUN;
                    end
                end
                S_DONE: begin
                    state_next = S_DONE;
                end
                default: begin
                    state_next = S_IDLE;
                    bcd_next   = '0;
                    pre_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= S_IDLE;
            bcd_reg     <= '0;
            target_reg  <= '0;
            pre_reg     <= '0;
            tick_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bcd_reg     <= bcd_next;
            target_reg  <= target_next;
            pre_reg     <= pre_next;
            tick_reg    <= tick_next;
            ovf_reg     <= ovf_next;
            running_reg <= (state_next == S_RUN);
            done_reg    <= (state_next == S_DONE);
        end
    end

    assign BCD     = bcd_reg;
    assign TICK    = tick_reg;
    assign OVF     = ovf_reg;
    assign RUNNING = running_reg;
    assign DONE    = done_reg;

endmodule
